// File: rtl/vec_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : vec_mem_port
// Brief    : Scalar/vector load-store bridge to an Avalon-MM SDRAM slave with
//            pipelined, multi-outstanding reads. Optional: VEC_MEM_STRIDE_EN.
// Revision : 1.0
// ============================================================================
module vec_mem_port #(
    parameter int LANES     = 16,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 25,
    parameter int MAX_OUTST = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic                    we,
    input  logic                    is_vec,
    input  logic [ADDR_W-1:0]       base_addr,
`ifdef VEC_MEM_STRIDE_EN
    input  logic [ADDR_W-1:0]       stride,
`endif
    input  logic [LANES*DATA_W-1:0] wdata_vec,
    output logic [LANES*DATA_W-1:0] rdata_vec,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_W-1:0]       avm_address,
    output logic [DATA_W/8-1:0]     avm_byteenable_n,
    output logic                    avm_chipselect,
    output logic [DATA_W-1:0]       avm_writedata,
    output logic                    avm_read_n,
    output logic                    avm_write_n,
    input  logic [DATA_W-1:0]       avm_readdata,
    input  logic                    avm_readdatavalid,
    input  logic                    avm_waitrequest
);

    localparam int            c_cnt_w     = $clog2(LANES + 1);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_max_outst = c_cnt_w'(MAX_OUTST);
    localparam logic [c_cnt_w-1:0] c_lanes     = c_cnt_w'(LANES);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_write = 2'd1;
    localparam logic [1:0] c_st_read  = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]              r_state;
    logic [c_cnt_w-1:0]      r_n;
    logic [LANES*DATA_W-1:0] r_wdata;
    logic [c_cnt_w-1:0]      r_wr_idx;
    logic [c_cnt_w-1:0]      r_rd_idx;
    logic [c_cnt_w-1:0]      r_rcv_idx;
    logic [c_cnt_w-1:0]      r_outst;
    logic [LANES*DATA_W-1:0] r_rdata;
    logic                    r_busy;
    logic                    r_done;
    logic [ADDR_W-1:0]       r_addr;
    logic [DATA_W-1:0]       r_wrdata;
    logic                    r_read_n;
    logic                    r_write_n;
    logic                    r_cs;
    logic [DATA_W/8-1:0]     r_be_n;
    logic [ADDR_W-1:0]       w_stride;

`ifdef VEC_MEM_STRIDE_EN
    logic [ADDR_W-1:0]       r_stride;
    assign w_stride = r_stride;
`else
    assign w_stride = ADDR_W'(1);
`endif

    logic               w_wr_acc;
    logic               w_rd_acc;
    logic               w_rcv;
    logic [c_cnt_w-1:0] w_wr_idx_nx;
    logic               w_wr_last;
    logic [c_cnt_w-1:0] w_wr_sel;
    logic [DATA_W-1:0]  w_wr_lane;
    logic [c_cnt_w-1:0] w_rd_idx_nx;
    logic [c_cnt_w-1:0] w_outst_nx;
    logic               w_rd_more;
    logic [c_cnt_w-1:0] w_rcv_nx;

    assign w_wr_acc    = !r_write_n && !avm_waitrequest;
    assign w_rd_acc    = !r_read_n && !avm_waitrequest;
    // Returns with nothing in flight are stale and must not advance rcv_idx.
    assign w_rcv       = avm_readdatavalid && (r_outst != '0);
    assign w_wr_idx_nx = r_wr_idx + c_one;
    assign w_wr_last   = (w_wr_idx_nx == r_n);
    assign w_wr_sel    = w_wr_last ? '0 : w_wr_idx_nx;
    assign w_wr_lane   = r_wdata[int'(w_wr_sel)*DATA_W +: DATA_W];
    assign w_rd_idx_nx = r_rd_idx + (w_rd_acc ? c_one : '0);
    assign w_outst_nx  = r_outst + (w_rd_acc ? c_one : '0) - (w_rcv ? c_one : '0);
    assign w_rd_more   = (w_rd_idx_nx < r_n) && (w_outst_nx < c_max_outst);
    assign w_rcv_nx    = r_rcv_idx + c_one;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_st_idle;
            r_n       <= '0;
            r_wdata   <= '0;
            r_wr_idx  <= '0;
            r_rd_idx  <= '0;
            r_rcv_idx <= '0;
            r_outst   <= '0;
            r_rdata   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_addr    <= '0;
            r_wrdata  <= '0;
            r_read_n  <= 1'b1;
            r_write_n <= 1'b1;
            r_cs      <= 1'b0;
            r_be_n    <= '1;
`ifdef VEC_MEM_STRIDE_EN
            r_stride  <= '0;
`endif
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (req) begin
                        r_n       <= is_vec ? c_lanes : c_one;
                        r_wdata   <= wdata_vec;
`ifdef VEC_MEM_STRIDE_EN
                        r_stride  <= stride;
`endif
                        r_wr_idx  <= '0;
                        r_rd_idx  <= '0;
                        r_rcv_idx <= '0;
                        r_outst   <= '0;
                        r_busy    <= 1'b1;
                        r_addr    <= base_addr;
                        r_cs      <= 1'b1;
                        r_be_n    <= '0;
                        if (we) begin
                            r_state   <= c_st_write;
                            r_write_n <= 1'b0;
                            r_wrdata  <= wdata_vec[DATA_W-1:0];
                        end else begin
                            r_state  <= c_st_read;
                            r_read_n <= 1'b0;
                        end
                    end
                end
                c_st_write: begin
                    // write_n already high means the last lane went out last cycle.
                    if (r_write_n) begin
                        r_state <= c_st_done;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (w_wr_acc) begin
                        if (w_wr_last) begin
                            r_write_n <= 1'b1;
                            r_cs      <= 1'b0;
                            r_be_n    <= '1;
                        end else begin
                            r_wr_idx <= w_wr_idx_nx;
                            r_addr   <= r_addr + w_stride;
                            r_wrdata <= w_wr_lane;
                        end
                    end
                end
                c_st_read: begin
                    r_rd_idx <= w_rd_idx_nx;
                    r_outst  <= w_outst_nx;
                    if (w_rd_acc) begin
                        r_addr <= r_addr + w_stride;
                    end
                    r_read_n <= !w_rd_more;
                    r_cs     <= w_rd_more;
                    r_be_n   <= w_rd_more ? '0 : '1;
                    if (w_rcv) begin
                        r_rdata[int'(r_rcv_idx)*DATA_W +: DATA_W] <= avm_readdata;
                        r_rcv_idx <= w_rcv_nx;
                        if (w_rcv_nx == r_n) begin
                            r_state <= c_st_done;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                c_st_done: begin
                    r_done  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign rdata_vec        = r_rdata;
    assign busy             = r_busy;
    assign done             = r_done;
    assign avm_address      = r_addr;
    assign avm_byteenable_n = r_be_n;
    assign avm_chipselect   = r_cs;
    assign avm_writedata    = r_wrdata;
    assign avm_read_n       = r_read_n;
    assign avm_write_n      = r_write_n;

endmodule
`default_nettype wire

// File: tb/tb_vec_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_mem_port
// Brief    : Scoreboard bench for vec_mem_port with a behavioural SDRAM slave.
// Revision : 1.0
// ============================================================================
module tb_vec_mem_port;

    typedef struct { logic [24:0] a; logic [15:0] d; } wr_t;
    typedef struct { int due; logic [15:0] d; } rt_t;
    typedef struct { bit ld; logic [255:0] v; } dn_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req = 1'b0;
    logic         we = 1'b0;
    logic         is_vec = 1'b0;
    logic [24:0]  base_addr = '0;
    logic [24:0]  stride_v = 25'd1;
    logic [255:0] wdata_vec = '0;
    logic [255:0] rdata_vec;
    logic         busy, done;
    logic [24:0]  avm_address;
    logic [1:0]   avm_byteenable_n;
    logic         avm_chipselect;
    logic [15:0]  avm_writedata;
    logic         avm_read_n, avm_write_n;
    logic [15:0]  avm_readdata = '0;
    logic         avm_readdatavalid = 1'b0;
    logic         avm_waitrequest = 1'b0;

    vec_mem_port dut (
        .clk               (clk),
        .reset             (reset),
        .req               (req),
        .we                (we),
        .is_vec            (is_vec),
        .base_addr         (base_addr),
`ifdef VEC_MEM_STRIDE_EN
        .stride            (stride_v),
`endif
        .wdata_vec         (wdata_vec),
        .rdata_vec         (rdata_vec),
        .busy              (busy),
        .done              (done),
        .avm_address       (avm_address),
        .avm_byteenable_n  (avm_byteenable_n),
        .avm_chipselect    (avm_chipselect),
        .avm_writedata     (avm_writedata),
        .avm_read_n        (avm_read_n),
        .avm_write_n       (avm_write_n),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_waitrequest   (avm_waitrequest)
    );

    always #5 clk = ~clk;

    wr_t          exp_wr[$];
    rt_t          rq[$];
    dn_t          exp_dn[$];
    logic [15:0]  mem     [logic [24:0]];
    logic [15:0]  ref_mem [logic [24:0]];
    logic [255:0] exp_vec = '0;

    int cyc = 0, n_checks = 0, n_pass = 0;
    int lat = 3, outst = 0, max_outst = 0, ret_cnt = 0, last_rdv_cyc = 0;
    int hold_cnt = 0, stale_left = 0, stall_left = 0;
    bit stall_arm = 1'b0;
    logic [24:0] stall_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // SDRAM slave model and write/command monitor, evaluated mid-cycle.
    always @(negedge clk) begin
        rt_t e;
        wr_t w;
        if (!reset) begin
            rq.delete();
            outst = 0;
            avm_readdatavalid = 1'b0;
            avm_waitrequest = 1'b0;
            stall_left = 0;
        end else begin
            avm_readdatavalid = 1'b0;
            if (stale_left > 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = 16'hDEAD;
                stale_left--;
            end else if (rq.size() > 0 && rq[0].due <= cyc) begin
                e = rq.pop_front();
                avm_readdatavalid = 1'b1;
                avm_readdata = e.d;
                ret_cnt++;
                outst--;
                last_rdv_cyc = cyc;
            end
            if (!avm_write_n && avm_address == 25'h105 && avm_writedata == 16'hA005) hold_cnt++;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) avm_waitrequest = 1'b0;
            end else if (stall_arm && !avm_write_n && avm_address == stall_addr) begin
                avm_waitrequest = 1'b1;
                stall_left = 4;
                stall_arm = 1'b0;
            end
            if (!avm_write_n || !avm_read_n)
                chk("cmd_cs_be", {253'd0, avm_chipselect, avm_byteenable_n}, 256'h4);
            if (!avm_waitrequest && !avm_write_n) begin
                mem[avm_address] = avm_writedata;
                if (exp_wr.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none expected", avm_address, avm_writedata);
                end else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", avm_address, w.a);
                    chk("wr_data", avm_writedata, w.d);
                end
            end
            if (!avm_waitrequest && !avm_read_n) begin
                e.due = cyc + lat;
                e.d = mem.exists(avm_address) ? mem[avm_address] : 16'h0;
                rq.push_back(e);
                outst++;
                if (outst > max_outst) max_outst = outst;
            end
        end
    end

    // Completion monitor.
    always @(negedge clk) begin
        dn_t d;
        if (reset && done) begin
            if (exp_dn.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: done pulse with no operation expected");
            end else begin
                d = exp_dn.pop_front();
                chk("busy_at_done", {255'd0, busy}, 256'd0);
                if (d.ld) chk("rdata_vec", rdata_vec, d.v);
            end
        end
    end

    task automatic start(input bit w, input bit v, input logic [24:0] b, input logic [255:0] wv);
        @(posedge clk); #1;
        req = 1'b1; we = w; is_vec = v; base_addr = b; wdata_vec = wv;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic wait_done(output int k, input bit poke);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) chk("busy_after_req", {255'd0, busy}, 256'd1);
            if (poke && k == 4) begin req = 1'b1; we = 1'b0; end
            if (poke && k == 5) req = 1'b0;
        end while (!done && k < 400);
        if (!done) begin
            n_checks++;
            $display("FAIL done_timeout: no done after %0d cycles", k);
        end
    endtask

    task automatic do_store(input bit v, input logic [24:0] b, input logic [255:0] wv,
                            input bit poke, input int extra);
        int n, k;
        dn_t dn;
        n = v ? 16 : 1;
        for (int i = 0; i < n; i++) begin
            wr_t w;
            w.a = b + 25'(i) * stride_v;
            w.d = wv[i*16 +: 16];
            exp_wr.push_back(w);
            ref_mem[w.a] = w.d;
        end
        dn.ld = 1'b0; dn.v = '0;
        exp_dn.push_back(dn);
        start(1'b1, v, b, wv);
        wait_done(k, poke);
        chk("store_done_cycle", 256'(k), 256'(n + 2 + extra));
        @(negedge clk);
        chk("done_single_pulse", {255'd0, done}, 256'd0);
        chk("busy_after_done", {255'd0, busy}, 256'd0);
        chk("wr_queue_drained", 256'(exp_wr.size()), 256'd0);
    endtask

    task automatic do_load(input bit v, input logic [24:0] b, input int latency, input bit cap_chk);
        int n, k;
        dn_t dn;
        logic [255:0] nv;
        logic [24:0] a;
        n = v ? 16 : 1;
        lat = latency;
        max_outst = 0;
        nv = exp_vec;
        for (int i = 0; i < n; i++) begin
            a = b + 25'(i) * stride_v;
            nv[i*16 +: 16] = ref_mem.exists(a) ? ref_mem[a] : 16'h0;
        end
        exp_vec = nv;
        dn.ld = 1'b1; dn.v = nv;
        exp_dn.push_back(dn);
        start(1'b0, v, b, '0);
        wait_done(k, 1'b0);
        chk("load_done_after_last_rdv", 256'(cyc), 256'(last_rdv_cyc + 1));
        @(negedge clk);
        chk("done_single_pulse", {255'd0, done}, 256'd0);
        chk("outst_le_max", {255'd0, max_outst <= 8}, 256'd1);
        if (cap_chk) chk("outst_reaches_max", 256'(max_outst), 256'd8);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},   {255'd0, busy}, 256'd0);
        chk({tag, "_done"},   {255'd0, done}, 256'd0);
        chk({tag, "_read_n"}, {255'd0, avm_read_n}, 256'd1);
        chk({tag, "_write_n"},{255'd0, avm_write_n}, 256'd1);
        chk({tag, "_cs"},     {255'd0, avm_chipselect}, 256'd0);
        chk({tag, "_addr"},   256'(avm_address), 256'd0);
        chk({tag, "_wdata"},  256'(avm_writedata), 256'd0);
        chk({tag, "_be_n"},   256'(avm_byteenable_n), 256'd3);
        chk({tag, "_rdata"},  rdata_vec, 256'd0);
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] va, v5, vs;
        int k, r0;
        for (int i = 0; i < 16; i++) begin
            va[i*16 +: 16] = 16'hA000 + 16'(i);
            v5[i*16 +: 16] = 16'h5555;
        end
        vs = 256'h1234;

        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        reset = 1'b1;

        do_store(1'b1, 25'h100, va, 1'b1, 0);
        do_load(1'b1, 25'h100, 3, 1'b0);

        hold_cnt = 0; stall_addr = 25'h105; stall_arm = 1'b1;
        do_store(1'b1, 25'h100, va, 1'b0, 4);
        chk("stall_hold_cycles", 256'(hold_cnt), 256'd5);

        do_load(1'b1, 25'h100, 12, 1'b1);

        do_store(1'b1, 25'h200, v5, 1'b0, 0);
        do_load(1'b1, 25'h200, 3, 1'b0);
        do_store(1'b0, 25'h1FFFFFF, vs, 1'b0, 0);
        do_load(1'b0, 25'h1FFFFFF, 3, 1'b0);
        chk("scalar_lane0", 256'(rdata_vec[15:0]), 256'h1234);
        chk("scalar_lane1", 256'(rdata_vec[31:16]), 256'h5555);
        chk("scalar_lane15", 256'(rdata_vec[255:240]), 256'h5555);

        do_store(1'b1, 25'h1FFFFFC, va, 1'b0, 0);
        do_load(1'b1, 25'h1FFFFFC, 3, 1'b0);

        // Abort a load after three returns, then feed stale returns in IDLE.
        lat = 3;
        r0 = ret_cnt;
        start(1'b0, 1'b1, 25'h100, '0);
        k = 0;
        while (ret_cnt < r0 + 3 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (ret_cnt < r0 + 3) begin
            n_checks++;
            $display("FAIL abort_wait_timeout: returns %0d required %0d", ret_cnt - r0, 3);
        end
        reset = 1'b0;
        #1;
        chk_reset_vals("midload_reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_vec = '0;
        stale_left = 2;
        repeat (4) @(negedge clk);
        chk("stale_rdata", rdata_vec, 256'd0);
        chk("stale_busy", {255'd0, busy}, 256'd0);
        chk("stale_done", {255'd0, done}, 256'd0);
        chk("stale_read_n", {255'd0, avm_read_n}, 256'd1);
        do_load(1'b1, 25'h100, 3, 1'b0);
        chk("post_reset_lane7", 256'(rdata_vec[127:112]), 256'hA007);

`ifdef VEC_MEM_STRIDE_EN
        stride_v = 25'd4;
        do_store(1'b1, 25'h10, va, 1'b0, 0);
        chk("stride_last_addr", 256'(ref_mem.exists(25'h4C)), 256'd1);
        do_load(1'b1, 25'h10, 3, 1'b0);
        stride_v = 25'd1;
`endif

        repeat (3) @(posedge clk);
        chk("done_queue_drained", 256'(exp_dn.size()), 256'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
